// File: rtl/ram_test_engine.sv
// External-SRAM sweep tester: writes a selectable pattern over the whole address
// space and/or reads it back, counting mismatches and capturing the first bad address.
module ram_test_engine #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 8,
   parameter int ERR_W    = 16,
   parameter int WAIT_CYC = 1
) (
   input  logic              sys_clk,
   input  logic              all_clear_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [1:0]        pattern_sel,
   input  logic [DATA_W-1:0] seed,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              ram_ce,
   output logic              ram_we,
   output logic              dir_ram,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [DATA_W-1:0] ram_data_out,
   output logic              ready,
   output logic              done,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_adr,
   output logic              first_err_valid
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, NEXT, FINISH} state_t;

   typedef struct packed {
      logic              two_pass;
      logic [1:0]        pat;
      logic [DATA_W-1:0] seed;
   } cfg_t;

   state_t            state, state_nxt;
   cfg_t              cfg;
   logic              wr_ph;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] adr_ext;
   logic [DATA_W-1:0] exp_data;
   logic              last_adr, last_wait, mismatch, in_sweep;

   // Address-derived patterns take the low DATA_W address bits, zero-extended.
   if (ADDR_W >= DATA_W) begin : g_trunc
      assign adr_ext = ram_adr[DATA_W-1:0];
   end else begin : g_zext
      assign adr_ext = {{(DATA_W-ADDR_W){1'b0}}, ram_adr};
   end

   always_comb begin
      exp_data = cfg.seed;
      case (cfg.pat)
         2'd1:    exp_data = adr_ext;
         2'd2:    exp_data = ~adr_ext;
         2'd3:    exp_data = cfg.seed ^ {DATA_W{ram_adr[0]}};
         default: exp_data = cfg.seed;
      endcase
   end

   assign last_adr  = &ram_adr;
   assign last_wait = (wait_cnt == 4'(WAIT_CYC));
   assign mismatch  = (rd_data != exp_data);
   assign in_sweep  = (state == SETUP) || (state == ACCESS) || (state == NEXT);

   assign ram_ce       = (state == ACCESS);
   assign dir_ram      = wr_ph && in_sweep;
   assign ram_we       = dir_ram;
   assign ram_data_out = dir_ram ? exp_data : '0;
   assign ready        = (state == IDLE);
   assign done         = (state == FINISH);

   always_ff @(posedge sys_clk) begin
      if (!all_clear_n) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (last_wait) state_nxt = NEXT;
         NEXT:    state_nxt = (last_adr && !(wr_ph && cfg.two_pass)) ? FINISH : SETUP;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && state != IDLE) state_nxt = IDLE;
   end

   always_ff @(posedge sys_clk) begin
      if (!all_clear_n) begin
         cfg             <= '0;
         wr_ph           <= 1'b0;
         wait_cnt        <= '0;
         rd_data         <= '0;
         ram_adr         <= '0;
         err_count       <= '0;
         first_err_adr   <= '0;
         first_err_valid <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            cfg             <= '{two_pass: mode[1], pat: pattern_sel, seed: seed};
            wr_ph           <= (mode != 2'd1);
            ram_adr         <= '0;
            err_count       <= '0;
            first_err_adr   <= '0;
            first_err_valid <= 1'b0;
         end
         if (state == SETUP) wait_cnt <= '0;
         if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 4'd1;
            if (last_wait && !wr_ph) rd_data <= ram_data_in;
         end
         // Abort on the NEXT cycle freezes results and address where they are.
         if (state == NEXT && !abort) begin
            if (!wr_ph && mismatch) begin
               if (err_count != '1) err_count <= err_count + ERR_W'(1);
               if (!first_err_valid) begin
                  first_err_adr   <= ram_adr;
                  first_err_valid <= 1'b1;
               end
            end
            if (!last_adr) begin
               ram_adr <= ram_adr + ADDR_W'(1);
            end else if (wr_ph && cfg.two_pass) begin
               ram_adr <= '0;
               wr_ph   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_test_engine.sv
// Directed bench for ram_test_engine (ADDR_W=4, WAIT_CYC=1, ERR_W=2) with a 16x8 SRAM model.
module tb_ram_test_engine;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int ERR_W  = 2;

   logic              sys_clk = 1'b0;
   logic              all_clear_n;
   logic              start, abort;
   logic [1:0]        mode, pattern_sel;
   logic [DATA_W-1:0] seed;
   logic [DATA_W-1:0] ram_data_in;
   logic              ram_ce, ram_we, dir_ram;
   logic [ADDR_W-1:0] ram_adr;
   logic [DATA_W-1:0] ram_data_out;
   logic              ready, done;
   logic [ERR_W-1:0]  err_count;
   logic [ADDR_W-1:0] first_err_adr;
   logic              first_err_valid;

   int n_cmp = 0;
   int n_err = 0;

   ram_test_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W), .WAIT_CYC(1)) dut (
      .sys_clk(sys_clk), .all_clear_n(all_clear_n), .start(start), .abort(abort),
      .mode(mode), .pattern_sel(pattern_sel), .seed(seed), .ram_data_in(ram_data_in),
      .ram_ce(ram_ce), .ram_we(ram_we), .dir_ram(dir_ram), .ram_adr(ram_adr),
      .ram_data_out(ram_data_out), .ready(ready), .done(done), .err_count(err_count),
      .first_err_adr(first_err_adr), .first_err_valid(first_err_valid)
   );

   always #5 sys_clk = ~sys_clk;

   // SRAM model: kind 0 ideal, 1 reads 0xFF with bit 0 stuck low at 5 and 9, 2 reads 0x00
   logic [DATA_W-1:0] mem [16];
   int ram_kind = 0;
   always @(posedge sys_clk) if (ram_ce && ram_we) mem[ram_adr] <= ram_data_out;
   assign ram_data_in = (ram_kind == 0) ? mem[ram_adr] :
                        (ram_kind == 1) ? (((ram_adr == 4'd5) || (ram_adr == 4'd9)) ? 8'hFE : 8'hFF) :
                        8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_ce"}, ram_ce, 0);
      chk({pfx, "_we"}, ram_we, 0);
      chk({pfx, "_dir"}, dir_ram, 0);
      chk({pfx, "_adr"}, ram_adr, 0);
      chk({pfx, "_dout"}, ram_data_out, 0);
      chk({pfx, "_ready"}, ready, 1);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_err"}, err_count, 0);
      chk({pfx, "_fea"}, first_err_adr, 0);
      chk({pfx, "_fev"}, first_err_valid, 0);
   endtask

   // Called #1 after an edge; returns #1 after the edge that sampled start.
   task automatic do_start(input logic [1:0] m, input logic [1:0] p, input logic [7:0] s,
                           input logic ab);
      mode = m; pattern_sel = p; seed = s; start = 1'b1; abort = ab;
      @(posedge sys_clk); #1;
      start = 1'b0; abort = 1'b0;
   endtask

   // Cycle 1 is the first SETUP; returns the cycle done is seen (-1 on timeout).
   task automatic sweep(input int kind, input int poke, output int dcyc, output int nce);
      int cyc;
      cyc = 1; nce = 0; dcyc = -1;
      while (cyc < 400) begin
         if (done) begin dcyc = cyc; break; end
         if (ram_ce) begin
            case (kind)
               1: begin
                  chk("wr_adr", ram_adr, nce / 2);
                  chk("wr_data", ram_data_out, nce / 2);
                  chk("wr_dir", {ram_we, dir_ram}, 3);
               end
               2: if (nce < 32) begin
                  chk("cb_data", ram_data_out, ((nce / 2) % 2 == 1) ? 8'hAA : 8'h55);
                  chk("cb_dir", {ram_we, dir_ram}, 3);
               end else chk("rd_dir", {ram_we, dir_ram}, 0);
               3: chk("rd_dir", {ram_we, dir_ram}, 0);
               default: ;
            endcase
            nce++;
         end
         start = (cyc == poke);
         @(posedge sys_clk); #1;
         cyc++;
      end
      start = 1'b0;
   endtask

   initial begin
      int dcyc, nce, found, seen_done, seen_ce;
      all_clear_n = 1'b0; start = 1'b0; abort = 1'b0;
      mode = 2'd0; pattern_sel = 2'd0; seed = 8'h00;
      repeat (2) @(posedge sys_clk);
      #1;
      chk_reset("rst");
      all_clear_n = 1'b1;
      @(posedge sys_clk); #1;

      // write-only, address pattern
      do_start(2'd0, 2'd1, 8'h00, 1'b0);
      chk("t1_busy", ready, 0);
      sweep(1, -1, dcyc, nce);
      chk("t1_done_cyc", dcyc, 65);
      chk("t1_ce_cnt", nce, 32);
      chk("t1_err", err_count, 0);
      chk("t1_end_adr", ram_adr, 15);
      @(posedge sys_clk); #1;
      chk("t1_ready", {ready, done}, 2'b10);
      chk("t1_idle_dir", {ram_we, dir_ram, ram_ce}, 0);

      // write then read, checkerboard 0x55/0xAA
      do_start(2'd2, 2'd3, 8'h55, 1'b0);
      sweep(2, -1, dcyc, nce);
      chk("t2_done_cyc", dcyc, 129);
      chk("t2_ce_cnt", nce, 64);
      chk("t2_err", err_count, 0);
      chk("t2_fev", first_err_valid, 0);
      for (int a = 0; a < 16; a++) chk("t2_mem", mem[a], (a % 2 == 1) ? 8'hAA : 8'h55);
      @(posedge sys_clk); #1;

      // mode 3 behaves as mode 2; inverted-address pattern
      do_start(2'd3, 2'd2, 8'h00, 1'b0);
      sweep(0, -1, dcyc, nce);
      chk("t3_done_cyc", dcyc, 129);
      chk("t3_err", err_count, 0);
      for (int a = 0; a < 16; a++) chk("t3_mem", mem[a], 8'hFF ^ a);
      @(posedge sys_clk); #1;

      // read-only against stuck bits at 5 and 9
      ram_kind = 1;
      do_start(2'd1, 2'd0, 8'hFF, 1'b0);
      sweep(3, -1, dcyc, nce);
      chk("t4_done_cyc", dcyc, 65);
      chk("t4_err", err_count, 2);
      chk("t4_fea", first_err_adr, 5);
      chk("t4_fev", first_err_valid, 1);
      @(posedge sys_clk); #1;

      // saturation: every read mismatches
      ram_kind = 2;
      do_start(2'd1, 2'd0, 8'hFF, 1'b0);
      sweep(3, -1, dcyc, nce);
      chk("t5_done_cyc", dcyc, 65);
      chk("t5_err_sat", err_count, 3);
      chk("t5_fea", first_err_adr, 0);
      chk("t5_fev", first_err_valid, 1);
      @(posedge sys_clk); #1;

      // abort during address 7 ACCESS of a read pass with one error already counted
      ram_kind = 1;
      do_start(2'd1, 2'd0, 8'hFF, 1'b0);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (ram_ce && ram_adr == 4'd7) begin found = 1; break; end
         @(posedge sys_clk); #1;
      end
      chk("t6_reach_adr7", found, 1);
      abort = 1'b1;
      @(posedge sys_clk); #1;
      abort = 1'b0;
      chk("t6_ce", ram_ce, 0);
      chk("t6_ready", ready, 1);
      chk("t6_adr", ram_adr, 7);
      chk("t6_err_kept", err_count, 1);
      chk("t6_fea_kept", {first_err_valid, first_err_adr}, 5'h15);
      seen_done = 0;
      for (int i = 0; i < 80; i++) begin
         seen_done |= int'(done);
         @(posedge sys_clk); #1;
      end
      chk("t6_no_done", seen_done, 0);
      chk("t6_adr_hold", ram_adr, 7);
      ram_kind = 0;
      do_start(2'd0, 2'd1, 8'h00, 1'b0);
      sweep(1, -1, dcyc, nce);
      chk("t6_rerun_cyc", dcyc, 65);
      chk("t6_rerun_fev", first_err_valid, 0);
      @(posedge sys_clk); #1;

      // reset mid read pass
      ram_kind = 2;
      do_start(2'd2, 2'd3, 8'h55, 1'b0);
      found = 0;
      for (int i = 0; i < 300; i++) begin
         if (ram_ce && !dir_ram && ram_adr == 4'd3) begin found = 1; break; end
         @(posedge sys_clk); #1;
      end
      chk("t7_reach_rd3", found, 1);
      chk("t7_err_pre", err_count, 3);
      all_clear_n = 1'b0;
      @(posedge sys_clk); #1;
      chk_reset("t7");
      all_clear_n = 1'b1;
      seen_ce = 0;
      for (int i = 0; i < 20; i++) begin
         seen_ce |= int'(ram_ce) | int'(!ready);
         @(posedge sys_clk); #1;
      end
      chk("t7_stays_idle", seen_ce, 0);

      // start with abort in IDLE starts; start while busy is ignored
      ram_kind = 0;
      do_start(2'd0, 2'd1, 8'h00, 1'b1);
      chk("t8_start_wins", ready, 0);
      sweep(0, 10, dcyc, nce);
      chk("t8_done_cyc", dcyc, 65);
      chk("t8_ce_cnt", nce, 32);
      @(posedge sys_clk); #1;
      chk("t8_ready", ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_test_engine.md
# ram_test_engine

Parametrised external-SRAM test engine and successor to the fixed 14-bit/8-bit RAM test unit. It sweeps the whole address space, writes a selectable data pattern and reads back with compare. It counts mismatches in a saturating counter and captures the first failing address. It sits between the SPI/control front end (start, mode, results) and the external SRAM pins, and adds programmable wait states, abort, and a done pulse.

## Interface
- ADDR_W, 14, RAM address width; sweep covers 0 .. 2^ADDR_W-1
- DATA_W, 8, RAM data width
- ERR_W, 16, error counter width
- WAIT_CYC, 1, extra cycles ram_ce is held per access (0..15)
- sys_clk  in  1  system clock, all logic on rising edge
- all_clear_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle start pulse; sampled only in IDLE
- abort  in  1  stop sweep; sampled every cycle
- mode  in  2  0 write-only, 1 read-compare-only, 2 write pass then read pass, 3 treated as 2
- pattern_sel  in  2  0 seed, 1 address, 2 ~address, 3 checkerboard (seed ^ {DATA_W{adr[0]}})
- seed  in  DATA_W  pattern base
- ram_data_in  in  DATA_W  read data from SRAM bus
- ram_ce  out  1  access strobe, active-high
- ram_we  out  1  1 = write access
- dir_ram  out  1  1 = FPGA drives data bus (write phase)
- ram_adr  out  ADDR_W  current address
- ram_data_out  out  DATA_W  write data
- ready  out  1  1 in IDLE
- done  out  1  one-cycle pulse at normal completion
- err_count  out  ERR_W  mismatch count, saturating
- first_err_adr  out  ADDR_W  address of first mismatch
- first_err_valid  out  1  first_err_adr is valid

## Operation
- States: IDLE, SETUP, ACCESS, NEXT, FINISH.
- Phase flag wr_ph: 1 = write pass, 0 = read pass.
- Pattern truncation: address patterns use the low DATA_W bits of the address, zero-extended if ADDR_W < DATA_W.
- IDLE:
  - On start: clear err_count, first_err_*, ram_adr; set wr_ph = (mode != 1); latch mode, pattern_sel and seed; go to SETUP.
  - start in any other state is ignored.
- SETUP (1 cycle):
  - ram_adr, ram_data_out, ram_we = wr_ph, dir_ram = wr_ph are driven stable; ram_ce = 0.
- ACCESS (WAIT_CYC+1 cycles):
  - ram_ce = 1; address, data and direction are held.
  - In the read pass, ram_data_in is registered on the last ACCESS cycle.
- NEXT (1 cycle):
  - ram_ce = 0.
  - Read pass: compare the registered data against the expected pattern for ram_adr. On mismatch, increment err_count (holds at 2^ERR_W-1). On the first mismatch, load first_err_adr and set first_err_valid.
  - If ram_adr == 2^ERR_W... correction: if ram_adr == 2^ADDR_W-1, the pass ends:
    - Write pass with latched mode 2: set ram_adr = 0, wr_ph = 0, go to SETUP.
    - Otherwise go to FINISH.
  - Else ram_adr + 1, go to SETUP.
- FINISH (1 cycle): done = 1, then IDLE.
- abort in any non-IDLE state:
  - ram_ce drops on the next edge and the state goes to IDLE.
  - No done pulse; err_count, first_err_* and ram_adr keep their values.
- dir_ram is 0 whenever not in a write-pass SETUP/ACCESS/NEXT, so the FPGA never drives the bus in IDLE.

## Timing
- Reset values: ram_ce 0, ram_we 0, dir_ram 0, ram_adr 0, ram_data_out 0, ready 1, done 0, err_count 0, first_err_adr 0, first_err_valid 0.
- Reset takes effect at the next edge from any state, including mid-sweep.
- Cycles per address: WAIT_CYC+3.
- One pass lasts 2^ADDR_W*(WAIT_CYC+3) cycles from the first SETUP.
- Latency:
  - start sampled at edge N gives ready = 0 from N+1; first SETUP is cycle N+1.
  - done asserts the cycle after the last NEXT; ready = 1 the cycle after done.
- err_count and first_err_* update at the edge ending NEXT and are stable from the following cycle.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.
- Simultaneous abort and the final NEXT: abort wins, no done pulse.

## Test plan
- ADDR_W=4, WAIT_CYC=1, mode 0, pattern 1, start:
  - 16 writes, ram_data_out = address 0..15, each with ram_ce high for 2 cycles.
  - done pulses exactly 65 cycles after start; err_count 0.
- Same parameters, mode 2, pattern 3, seed 0x55, ideal RAM model:
  - write pass drives 0x55/0xAA alternating, then the read pass runs.
  - err_count 0, first_err_valid 0, done at 129 cycles.
- mode 1, RAM model stuck bit 0 at address 5 and 9, pattern 0, seed 0xFF:
  - err_count 2, first_err_adr 5, first_err_valid 1.
- ERR_W=2, mode 1 against a RAM returning 0x00, seed 0xFF: err_count saturates at 3, no wrap.
- abort asserted during address 7 ACCESS:
  - ram_ce low the next cycle, ready = 1, done never pulses, ram_adr stays 7.
  - A new start runs a full sweep.
- all_clear_n low mid-read-pass for 1 cycle: all outputs reach reset values at that edge; start pulses during busy are ignored (no sweep restart).
